// File: rtl/trivium_pkg.sv
// Shared encodings for the Trivium key/IV loader: FSM states, host word map, default widths.
package trivium_pkg;

    localparam int unsigned DEF_KEY_W = 80;
    localparam int unsigned DEF_IV_W  = 80;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StShiftKey = 3'd1,
        StShiftIv  = 3'd2,
        StInit     = 3'd3,
        StWaitBusy = 3'd4
    } state_e;

    localparam logic [2:0] KEY_W0 = 3'd0;
    localparam logic [2:0] KEY_W1 = 3'd1;
    localparam logic [2:0] KEY_W2 = 3'd2;
    localparam logic [2:0] IV_W0  = 3'd3;
    localparam logic [2:0] IV_W1  = 3'd4;
    localparam logic [2:0] IV_W2  = 3'd5;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register: load has priority over shift, LSB is the serial output.
module piso_shreg #(
    parameter int unsigned WIDTH = 80
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_dat_i,
    input  logic             shift_i,
    output logic             ser_o
);

    logic [WIDTH-1:0] sr_q;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= load_dat_i;
        end else if (shift_i) begin
            sr_q <= {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    assign ser_o = sr_q[0];

endmodule

// File: rtl/trivium_kiv_loader.sv
// Host-side serializer: stores key/IV words, streams key then IV LSB-first over valid/ready,
// then pulses the core's init request and waits out its busy period.
module trivium_kiv_loader
    import trivium_pkg::*;
#(
    parameter int unsigned KEY_W = DEF_KEY_W,
    parameter int unsigned IV_W  = DEF_IV_W
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        wr_i,
    input  logic [2:0]  wr_addr_i,
    input  logic [31:0] wr_dat_i,
    input  logic        start_i,
    input  logic        core_busy_i,
    input  logic        ser_rdy_i,
    output logic        ser_dat_o,
    output logic        ser_vld_o,
    output logic        ser_last_o,
    output logic        init_o,
    output logic        ready_o,
    output logic        err_o
);

    localparam int unsigned MAX_W = (KEY_W > IV_W) ? KEY_W : IV_W;
    localparam int unsigned CNT_W = $clog2(MAX_W);

    state_e            state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [IV_W-1:0]   iv_q, iv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              vld_q, vld_d;
    logic              last_q, last_d;
    logic              init_q, init_d;
    logic              seen_q, seen_d;
    logic              err_q, err_d;
    logic              load;
    logic [MAX_W-1:0]  load_dat;
    logic              xfer;
    logic [95:0]       key_wide, iv_wide;

    assign xfer = vld_q & ser_rdy_i;

    // Word-granular storage update; bits above KEY_W/IV_W fall off when narrowed back.
    always_comb begin
        key_wide = 96'(key_q);
        iv_wide  = 96'(iv_q);
        if (state_q == StIdle && wr_i) begin
            case (wr_addr_i)
                KEY_W0:  key_wide[31:0]  = wr_dat_i;
                KEY_W1:  key_wide[63:32] = wr_dat_i;
                KEY_W2:  key_wide[95:64] = wr_dat_i;
                IV_W0:   iv_wide[31:0]   = wr_dat_i;
                IV_W1:   iv_wide[63:32]  = wr_dat_i;
                IV_W2:   iv_wide[95:64]  = wr_dat_i;
                default: ;
            endcase
        end
        key_d = key_wide[KEY_W-1:0];
        iv_d  = iv_wide[IV_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vld_d    = vld_q;
        last_d   = last_q;
        init_d   = 1'b0;
        seen_d   = seen_q;
        err_d    = err_q;
        load     = 1'b0;
        load_dat = '0;

        if (state_q != StIdle && (start_i || (wr_i && wr_addr_i <= IV_W2))) begin
            err_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    // key_d so a same-cycle write is already visible to this load
                    state_d  = StShiftKey;
                    cnt_d    = '0;
                    vld_d    = 1'b1;
                    load     = 1'b1;
                    load_dat = MAX_W'(key_d);
                end
            end
            StShiftKey: begin
                if (xfer) begin
                    if (cnt_q == CNT_W'(KEY_W - 1)) begin
                        state_d  = StShiftIv;
                        cnt_d    = '0;
                        load     = 1'b1;
                        load_dat = MAX_W'(iv_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StShiftIv: begin
                if (xfer) begin
                    if (cnt_q == CNT_W'(IV_W - 1)) begin
                        state_d = StInit;
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        init_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        last_d = (cnt_q == CNT_W'(IV_W - 2));
                    end
                end
            end
            StInit: begin
                state_d = StWaitBusy;
                seen_d  = core_busy_i;
            end
            StWaitBusy: begin
                if (!seen_q) begin
                    seen_d = core_busy_i;
                end else if (!core_busy_i) begin
                    state_d = StIdle;
                    seen_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= StIdle;
            key_q   <= '0;
            iv_q    <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            init_q  <= 1'b0;
            seen_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            iv_q    <= iv_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            init_q  <= init_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
        end
    end

    piso_shreg #(
        .WIDTH (MAX_W)
    ) u_shreg (
        .clk_i      (clk_i),
        .n_rst_i    (n_rst_i),
        .load_i     (load),
        .load_dat_i (load_dat),
        .shift_i    (xfer),
        .ser_o      (ser_dat_o)
    );

    assign ser_vld_o  = vld_q;
    assign ser_last_o = last_q;
    assign init_o     = init_q;
    assign err_o      = err_q;
    assign ready_o    = (state_q == StIdle);

endmodule
